dmem_init_arbiter: RTL and testbench

Owns the i281 data-memory write port. After reset, and on request, it sequences the 16 user-data initial bytes into data memory, one byte per cycle, and stalls the CPU while it does so. In normal run it shares the write port between the CPU datapath and an external switch/debug writer, with fixed CPU priority. It sits between the user-data constant block, the CPU store path and the data-memory register file.

---
 rtl/dmem_init_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dmem_init_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_init_arbiter.sv
// dmem_init_arbiter: owner of the i281 data-memory write port.
// After reset, or on a reload request, it streams the NUM_BYTES initial bytes
// into data memory while holding the CPU stalled. In run mode it arbitrates the
// write port between the CPU store path (priority) and an external writer.
// Optional build macro: DMEM_STARVE_GUARD_EN. When defined, an external request
// passed over STARVE_LIMIT times is forced through ahead of the CPU.
module dmem_init_arbiter #(
    parameter int NUM_BYTES    = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset_n,
    input  logic [NUM_BYTES*DATA_W-1:0] i_init_bus,
    input  logic                        i_reload_req,
    input  logic                        i_cpu_we,
    input  logic [ADDR_W-1:0]           i_cpu_addr,
    input  logic [DATA_W-1:0]           i_cpu_wdata,
    input  logic                        i_ext_req,
    input  logic [ADDR_W-1:0]           i_ext_addr,
    input  logic [DATA_W-1:0]           i_ext_wdata,
    output logic                        o_ext_ack,
    output logic                        o_mem_we,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_wdata,
    output logic                        o_cpu_stall,
    output logic                        o_load_done
);

    // ST_DONE is the first run edge after a load: it only pulses load_done,
    // so ext_ack and load_done can never coincide.
    typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_IDX = ADDR_W'(NUM_BYTES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_next;

    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_ext_ack;
    logic                r_cpu_stall;
    logic                r_load_done;

    logic                w_mem_we_next;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [DATA_W-1:0]   w_mem_wdata_next;
    logic                w_ext_ack_next;
    logic                w_cpu_stall_next;
    logic                w_load_done_next;

    logic [DATA_W-1:0]   w_init_bytes [NUM_BYTES];
    logic                w_run_ok;
    logic                w_force_ext;
    logic                w_grant_cpu;
    logic                w_grant_ext;

    // Slice the flat initial image into addressable bytes.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_init_bytes
            assign w_init_bytes[gi] = i_init_bus[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // A run-mode grant is possible only when no reload is requested this cycle.
    assign w_run_ok    = (r_state == ST_RUN) && !i_reload_req;
    assign w_grant_ext = w_run_ok && (w_force_ext || (!i_cpu_we && i_ext_req));
    assign w_grant_cpu = w_run_ok && i_cpu_we && !w_force_ext;

`ifdef DMEM_STARVE_GUARD_EN
    localparam int             SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  LP_LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] r_starve_cnt;

    assign w_force_ext = w_run_ok && i_ext_req && (r_starve_cnt >= LP_LIMIT);

    // Count run cycles in which a pending external request lost to the CPU.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_starve_cnt <= '0;
        end else if ((r_state != ST_RUN) || i_reload_req || w_grant_ext) begin
            r_starve_cnt <= '0;
        end else if (i_ext_req && (r_starve_cnt < LP_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end
`else
    assign w_force_ext = 1'b0;
`endif

    // State register and load byte counter.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state: load runs to the last byte, one done edge, then run until reload.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD: if (r_cnt == LP_LAST_IDX) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_RUN;
            ST_RUN:  if (i_reload_req) w_state_next = ST_LOAD;
            default: w_state_next = ST_LOAD;
        endcase
    end

    // Output decode: next values of the registered port and the byte counter.
    always_comb begin
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_ext_ack_next   = 1'b0;
        w_cpu_stall_next = 1'b0;
        w_load_done_next = 1'b0;
        w_cnt_next       = r_cnt;
        case (r_state)
            ST_LOAD: begin
                w_mem_we_next    = 1'b1;
                w_mem_addr_next  = r_cnt;
                w_mem_wdata_next = w_init_bytes[r_cnt];
                w_cpu_stall_next = 1'b1;
                w_cnt_next       = r_cnt + ADDR_W'(1);
            end
            ST_DONE: begin
                w_load_done_next = 1'b1;
                w_cnt_next       = '0;
            end
            ST_RUN: begin
                if (i_reload_req) begin
                    w_cpu_stall_next = 1'b1;
                    w_cnt_next       = '0;
                end else if (w_grant_cpu) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = i_cpu_addr;
                    w_mem_wdata_next = i_cpu_wdata;
                end else if (w_grant_ext) begin
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = i_ext_addr;
                    w_mem_wdata_next = i_ext_wdata;
                    w_ext_ack_next   = 1'b1;
                    w_cpu_stall_next = w_force_ext;
                end
            end
            default: ;
        endcase
    end

    // Output registers: every port is driven straight from a flop.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ext_ack   <= 1'b0;
            r_cpu_stall <= 1'b1;
            r_load_done <= 1'b0;
        end else begin
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_ext_ack   <= w_ext_ack_next;
            r_cpu_stall <= w_cpu_stall_next;
            r_load_done <= w_load_done_next;
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_ext_ack   = r_ext_ack;
    assign o_cpu_stall = r_cpu_stall;
    assign o_load_done = r_load_done;

endmodule

// File: tb/tb_dmem_init_arbiter.sv
// Testbench for dmem_init_arbiter: randomized stimulus against a cycle-count
// reference model; one task per scenario, each comparing the whole output port.
module tb_dmem_init_arbiter;

    localparam int NB  = 16;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LIM = 8;
    localparam int VW  = AW + DW + 4;

`ifdef DMEM_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NB*DW-1:0] init_bus;
    logic             reload;
    logic             cpu_we;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             ext_req;
    logic [AW-1:0]    ext_addr;
    logic [DW-1:0]    ext_wdata;
    logic             ext_ack;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             cpu_stall;
    logic             load_done;

    // expected outputs and model state
    logic             e_we, e_ack, e_stall, e_done;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_wd;
    int               m_lc;      // edges since the load started (NB+1 and beyond = running)
    int               m_starve;  // run cycles an ext request has been passed over

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dmem_init_arbiter #(
        .NUM_BYTES(NB), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_init_bus  (init_bus),
        .i_reload_req(reload),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .i_ext_req   (ext_req),
        .i_ext_addr  (ext_addr),
        .i_ext_wdata (ext_wdata),
        .o_ext_ack   (ext_ack),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_cpu_stall (cpu_stall),
        .o_load_done (load_done)
    );

    function automatic logic [VW-1:0] act_vec();
        return {mem_we, mem_addr, mem_wdata, ext_ack, cpu_stall, load_done};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_we, e_addr, e_wd, e_ack, e_stall, e_done};
    endfunction

    // One clock: the model applies the rules to the inputs sampled at this edge,
    // then outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        e_ack  = 1'b0;
        e_done = 1'b0;
        if (!rst_n) begin
            e_we = 1'b0; e_addr = '0; e_wd = '0; e_stall = 1'b1;
            m_lc = 0; m_starve = 0;
        end else if (m_lc < NB) begin
            e_we = 1'b1; e_addr = AW'(m_lc); e_wd = init_bus[m_lc*DW +: DW];
            e_stall = 1'b1; m_lc++; m_starve = 0;
        end else if (m_lc == NB) begin
            e_we = 1'b0; e_stall = 1'b0; e_done = 1'b1; m_lc++;
        end else if (reload) begin
            e_we = 1'b0; e_stall = 1'b1; m_lc = 0; m_starve = 0;
        end else if (GUARD && ext_req && m_starve >= LIM) begin
            e_we = 1'b1; e_addr = ext_addr; e_wd = ext_wdata;
            e_ack = 1'b1; e_stall = 1'b1; m_starve = 0;
        end else if (cpu_we) begin
            e_we = 1'b1; e_addr = cpu_addr; e_wd = cpu_wdata; e_stall = 1'b0;
            if (ext_req) m_starve++;
        end else if (ext_req) begin
            e_we = 1'b1; e_addr = ext_addr; e_wd = ext_wdata;
            e_ack = 1'b1; e_stall = 1'b0; m_starve = 0;
        end else begin
            e_we = 1'b0; e_stall = 1'b0;
        end
        #1;
        if (mem_we || ext_ack || load_done)
            $display("[%0d] we=%0d addr=%0d data=%02h ack=%0d stall=%0d done=%0d",
                     cyc, mem_we, mem_addr, mem_wdata, ext_ack, cpu_stall, load_done);
    endtask

    task automatic test_reset();
        logic [7:0] img [NB] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h04,
                                 8'h40, 8'h08, 8'h40, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03};
        for (int k = 0; k < NB; k++) init_bus[k*DW +: DW] = img[k];
        rst_n = 1'b0; reload = 1'b0; cpu_we = 1'b0; ext_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; ext_addr = '0; ext_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    // Load after release, with CPU stores and an ext request arriving during it.
    task automatic test_init_load();
        int done_at = -1;
        int writes  = 0;
        rst_n = 1'b1; cpu_we = 1'b1; ext_req = 1'b1;
        ext_addr = 4'd7; ext_wdata = 8'hE7;
        for (int i = 1; i <= NB + 1; i++) begin
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            step();
            if (load_done) done_at = i;
            if (mem_we) writes++;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL init_load cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (done_at != NB + 1 || writes != NB) begin
            bad++;
            $display("FAIL load_timing got done_at=%0d writes=%0d want %0d/%0d",
                     done_at, writes, NB + 1, NB);
        end
        cpu_we = 1'b0; ext_req = 1'b0;
    endtask

    task automatic test_cpu_write();
        cpu_we = 1'b1; cpu_addr = 4'd5; cpu_wdata = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            step();
            cpu_we = 1'b0;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL cpu_write cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    // Ext request waits behind 4 CPU stores, then is served and dropped.
    task automatic test_cpu_priority();
        int ack_at = -1;
        ext_req = 1'b1; ext_addr = 4'd2; ext_wdata = 8'h33;
        for (int i = 1; i <= 7; i++) begin
            cpu_we = (i <= 4);
            cpu_addr = AW'(8 + i); cpu_wdata = DW'($urandom);
            step();
            if (ext_ack) begin
                if (ack_at < 0) ack_at = i;
                ext_req = 1'b0;
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL cpu_priority cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (ack_at != 5) begin
            bad++;
            $display("FAIL ext_after_cpu got ack_at=%0d want 5", ack_at);
        end
    endtask

    // Reload with a simultaneous ext request, then a reset pulse mid-reload.
    task automatic test_reload();
        int ack_at = -1;
        for (int k = 0; k < NB; k++) init_bus[k*DW +: DW] = DW'($urandom);
        reload = 1'b1; ext_req = 1'b1; ext_addr = 4'd9; ext_wdata = 8'h5C;
        cpu_we = 1'b1; cpu_addr = 4'd1; cpu_wdata = 8'h11;
        for (int i = 0; i <= NB + 3; i++) begin
            step();
            reload = 1'b0; cpu_we = 1'b0;
            if (ext_ack) begin
                if (ack_at < 0) ack_at = i;
                ext_req = 1'b0;
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reload cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (ack_at != NB + 2) begin
            bad++;
            $display("FAIL ext_after_reload got ack_at=%0d want %0d", ack_at, NB + 2);
        end
        reload = 1'b1;
        for (int i = 0; i < 6 + 1 + NB + 2; i++) begin
            rst_n = (i != 6);
            step();
            reload = 1'b0;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reset_mid_reload cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef DMEM_STARVE_GUARD_EN
    task automatic test_starve();
        int ack_at = -1;
        cpu_we = 1'b1; ext_req = 1'b1; ext_addr = 4'd12; ext_wdata = 8'hC3;
        for (int i = 1; i <= LIM + 4; i++) begin
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            step();
            if (ext_ack) begin
                if (ack_at < 0) ack_at = i;
                ext_req = 1'b0;
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL starve cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
        total++;
        if (ack_at != LIM + 1) begin
            bad++;
            $display("FAIL starve_grant got ack_at=%0d want %0d", ack_at, LIM + 1);
        end
        cpu_we = 1'b0;
    endtask
`endif

    // Random traffic with a well-behaved ext requester, rare reloads and resets.
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            reload = ($urandom_range(0, 39) == 0);
            cpu_we = $urandom_range(0, 1) == 1;
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            if (!ext_req && $urandom_range(0, 9) < 4) begin
                ext_req = 1'b1; ext_addr = AW'($urandom); ext_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 99) == 0) init_bus[$urandom_range(0, NB-1)*DW +: DW] = DW'($urandom);
            step();
            if (ext_ack) ext_req = 1'b0;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_load();
        test_cpu_write();
        test_cpu_priority();
        test_reload();
`ifdef DMEM_STARVE_GUARD_EN
        test_starve();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
